// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit scheduler
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sched_state_e;

  localparam int BURST_W = 8;
  localparam int HOLD_W  = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // one extra bit so ptr+k never overflows before the wrap subtract
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - message-locked round-robin sharing of one UART byte transmitter
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 1023,
  localparam int IDW         = id_width(NREQ)
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  output logic [NREQ-1:0]     grant,
  output logic [IDW-1:0]      cur_id,
  output logic                busy,
  output logic                timeout_evt
);

  sched_state_e       state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [IDW-1:0]     cur_id_q, cur_id_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic [NREQ-1:0]    arb_gnt;
  logic [IDW-1:0]     arb_id;
  logic               arb_any;

  uart_byte_t         req_bytes [NREQ];
  logic               owner_valid;
  logic               owner_last;
  uart_byte_t         owner_data;
  logic               beat;
  logic               release_now;
  logic [IDW-1:0]     next_ptr;

  for (genvar i = 0; i < NREQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[8*i +: 8];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  assign owner_valid = req_valid[cur_id_q];
  assign owner_last  = req_last[cur_id_q];
  assign owner_data  = req_bytes[cur_id_q];
  assign next_ptr    = (cur_id_q == IDW'(NREQ-1)) ? '0 : cur_id_q + IDW'(1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cur_id_d    = cur_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    tx_valid    = 1'b0;
    tx_data     = '0;
    req_ready   = '0;
    timeout_evt = 1'b0;
    beat        = 1'b0;
    release_now = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        hold_cnt_d  = '0;
        if (arb_any) begin
          state_d  = ST_GRANT;
          grant_d  = arb_gnt;
          cur_id_d = arb_id;
        end
      end

      ST_GRANT: begin
        tx_valid            = owner_valid;
        tx_data             = owner_data;
        req_ready[cur_id_q] = tx_ready;
        beat                = owner_valid & tx_ready;

        if (beat && burst_cnt_q != {BURST_W{1'b1}}) begin
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
        // a stalled transmitter with valid held high is not idleness
        hold_cnt_d = owner_valid ? '0 : hold_cnt_q + HOLD_W'(1);

        if (beat && (owner_last || burst_cnt_q == BURST_W'(MAX_BURST-1))) begin
          release_now = 1'b1;
        end else if (!owner_valid && hold_cnt_q == HOLD_W'(HOLD_TIMEOUT-1)) begin
          release_now = 1'b1;
          timeout_evt = 1'b1;
        end

        if (release_now) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      cur_id_q    <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cur_id_q    <= cur_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign grant  = grant_q;
  assign cur_id = cur_id_q;
  assign busy   = (state_q == ST_GRANT);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  localparam int N    = 4;
  localparam int MAXB = 16;
  localparam int HOLD = 8;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic [7:0] dly;
  } ent_t;

  logic          sysclk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic [N-1:0]  grant;
  logic [1:0]    cur_id;
  logic          busy;
  logic          timeout_evt;

  int n_cmp = 0;
  int n_bad = 0;

  ent_t       src_q [N][$];
  logic [8:0] exp_q [N][$];
  ent_t       cur_ent [N];
  int         dly_left [N];
  logic [N-1:0] cur_active;
  logic [N-1:0] acc;

  int    m_owner = -1;
  int    m_ptr = 0;
  int    m_cnt = 0;
  int    m_low = 0;
  int    m_timeouts = 0;
  string rel_log = "";
  int    mo;
  logic [8:0] me;

  uart_tx_scheduler #(
    .NREQ         (N),
    .MAX_BURST    (MAXB),
    .HOLD_TIMEOUT (HOLD)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant       (grant),
    .cur_id      (cur_id),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rel(input string nm, input string exp);
    n_cmp++;
    if (rel_log != exp) begin
      n_bad++;
      $display("FAIL %s: release log got '%s' expected '%s'", nm, rel_log, exp);
    end
  endtask

  // Stimulus issue: the byte goes to the requester's source and the scoreboard together.
  task automatic push_byte(input int r, input logic [7:0] b, input logic last, input int dly);
    ent_t e;
    e.b = b;
    e.last = last;
    e.dly = 8'(dly);
    src_q[r].push_back(e);
    exp_q[r].push_back({last, b});
  endtask

  task automatic push_msg(input int r, input int len);
    for (int i = 0; i < len; i++) begin
      push_byte(r, 8'($urandom), (i == len-1), 0);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      dly_left[i] = 0;
    end
    cur_active = '0;
    req_valid = '0;
    req_last = '0;
  endtask

  task automatic do_reset();
    @(posedge sysclk); #3;
    reset = 1'b1;
    clear_src();
    @(posedge sysclk); #3;
    reset = 1'b0;
    rel_log = "";
  endtask

  function automatic bit all_done();
    bit d;
    d = (m_owner < 0) && (cur_active == '0);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) d = 1'b0;
    end
    return d;
  endfunction

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      @(posedge sysclk); #3;
      n++;
    end
    chk({nm, "_drain"}, 32'(n < budget), 1);
    repeat (2) @(posedge sysclk);
    #3;
  endtask

  // Requester models: each byte waits out its delay with valid low, then holds until accepted.
  initial begin
    forever begin
      @(negedge sysclk);
      acc = req_valid & req_ready;
      @(posedge sysclk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) cur_active[i] = 1'b0;
        if (!cur_active[i] && src_q[i].size() > 0) begin
          cur_ent[i] = src_q[i].pop_front();
          dly_left[i] = int'(cur_ent[i].dly);
          cur_active[i] = 1'b1;
        end
        if (cur_active[i] && dly_left[i] == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*8 +: 8] = cur_ent[i].b;
          req_last[i] = cur_ent[i].last;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i] = 1'b0;
          if (cur_active[i]) dly_left[i]--;
        end
      end
    end
  end

  // Monitor: reference model of ownership plus the per-requester byte scoreboard.
  always @(negedge sysclk) begin
    if (reset) begin
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_cur_id", 32'(cur_id), 0);
      chk("rst_timeout", 32'(timeout_evt), 0);
      m_owner = -1;
      m_ptr = 0;
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else if (m_owner < 0) begin
      chk("idle_grant", 32'(grant), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_tx_valid", 32'(tx_valid), 0);
      chk("idle_req_ready", 32'(req_ready), 0);
      chk("idle_timeout", 32'(timeout_evt), 0);
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      m_cnt = 0;
      m_low = 0;
    end else begin
      mo = m_owner;
      chk("grant", 32'(grant), 32'(1) << mo);
      chk("cur_id", 32'(cur_id), 32'(mo));
      chk("busy", 32'(busy), 1);
      chk("tx_valid", 32'(tx_valid), 32'(req_valid[mo]));
      chk("tx_data_mux", 32'(tx_data), 32'(req_data[mo*8 +: 8]));
      chk("req_ready", 32'(req_ready), tx_ready ? (32'(1) << mo) : 0);
      if (req_valid[mo] && tx_ready) begin
        chk("beat_timeout", 32'(timeout_evt), 0);
        chk("byte_expected", 32'(exp_q[mo].size() != 0), 1);
        if (exp_q[mo].size() != 0) begin
          me = exp_q[mo].pop_front();
          chk("tx_byte", 32'(tx_data), 32'(me[7:0]));
          m_cnt++;
          m_low = 0;
          if (me[8] || m_cnt == MAXB) begin
            rel_log = {rel_log, $sformatf("%0d:%0d,", mo, m_cnt)};
            m_owner = -1;
            m_ptr = (mo + 1) % N;
          end
        end
      end else if (!req_valid[mo]) begin
        m_low++;
        if (m_low == HOLD) begin
          chk("timeout_pulse", 32'(timeout_evt), 1);
          m_timeouts++;
          rel_log = {rel_log, $sformatf("%0d:%0d,", mo, m_cnt)};
          m_owner = -1;
          m_ptr = (mo + 1) % N;
        end else begin
          chk("no_timeout", 32'(timeout_evt), 0);
        end
      end else begin
        m_low = 0;
        chk("stall_timeout", 32'(timeout_evt), 0);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  int t0;
  int wn;
  logic pat [14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    reset = 1'b1;
    tx_ready = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    acc = '0;
    clear_src();
    repeat (3) @(posedge sysclk);

    // single 3-byte message from requester 2, then rr_ptr must sit at 3
    do_reset();
    push_byte(2, 8'h41, 1'b0, 0);
    push_byte(2, 8'h42, 1'b0, 0);
    push_byte(2, 8'h43, 1'b1, 0);
    drain("t1", 100);
    chk_rel("t1_single", "2:3,");
    rel_log = "";
    push_msg(0, 1);
    push_msg(3, 1);
    drain("t1b", 100);
    chk_rel("t1_ptr_after_release", "3:1,0:1,");

    // all four requesters with 2-byte messages
    do_reset();
    for (int r = 0; r < N; r++) push_msg(r, 2);
    drain("t2", 200);
    chk_rel("t2_round_robin", "0:2,1:2,2:2,3:2,");

    // forced rotation after MAX_BURST bytes
    do_reset();
    push_msg(1, 20);
    repeat (2) @(posedge sysclk);
    #3;
    push_msg(3, 3);
    drain("t3", 300);
    chk_rel("t3_burst", "1:16,3:3,1:4,");

    // hold timeout: a 7-cycle gap survives, an 8-cycle gap revokes
    do_reset();
    t0 = m_timeouts;
    push_byte(0, 8'h10, 1'b0, 0);
    push_byte(0, 8'h11, 1'b0, 0);
    push_byte(0, 8'h12, 1'b0, HOLD-1);
    push_byte(0, 8'h13, 1'b1, HOLD);
    drain("t4", 200);
    chk_rel("t4_timeout", "0:3,0:1,");
    chk("t4_timeout_count", 32'(m_timeouts - t0), 1);

    // transmitter stalls: accepted only on ready, long stall is not a timeout
    do_reset();
    t0 = m_timeouts;
    push_msg(2, 4);
    wn = 0;
    while (!busy && wn < 20) begin
      @(posedge sysclk); #2;
      wn++;
    end
    chk("t5_granted", 32'(busy), 1);
    for (int k = 0; k < 14; k++) begin
      tx_ready = pat[k];
      @(posedge sysclk); #2;
    end
    tx_ready = 1'b1;
    drain("t5", 100);
    chk_rel("t5_stall", "2:4,");
    chk("t5_no_timeout", 32'(m_timeouts - t0), 0);

    // asynchronous reset mid-message, then arbitration restarts at 0
    push_msg(2, 10);
    repeat (4) @(posedge sysclk);
    #2;
    chk("t6_busy_before_reset", 32'(busy), 1);
    #1;
    reset = 1'b1;
    clear_src();
    #1;
    chk("t6_async_grant", 32'(grant), 0);
    chk("t6_async_tx_valid", 32'(tx_valid), 0);
    chk("t6_async_req_ready", 32'(req_ready), 0);
    chk("t6_async_busy", 32'(busy), 0);
    @(posedge sysclk); #3;
    reset = 1'b0;
    rel_log = "";
    for (int r = 0; r < N; r++) push_msg(r, 1);
    drain("t6", 100);
    chk_rel("t6_restart", "0:1,1:1,2:1,3:1,");

    // randomized traffic with random transmitter back-pressure and gaps
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge sysclk); #2;
      tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        int r;
        int len;
        r = $urandom_range(0, N-1);
        len = $urandom_range(1, 24);
        if (src_q[r].size() < 40) begin
          for (int i = 0; i < len; i++) begin
            push_byte(r, 8'($urandom), (i == len-1),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(HOLD-2, HOLD+2)
                                                  : $urandom_range(0, 1));
          end
        end
      end
    end
    tx_ready = 1'b1;
    drain("rand", 6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART byte transmitter between `NREQ` requesters (debug console, status reporter, echo path, etc.). Each requester streams bytes with valid/ready and marks the final byte of a message with `last`. The scheduler locks the grant for a whole message so bytes never interleave on the line. It sits between the requesters and the transmitter's byte-level valid/ready input.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `MAX_BURST`, 16: maximum bytes per grant before forced rotation (1..255).
- `HOLD_TIMEOUT`, 1023: `sysclk` cycles a granted requester may leave `req_valid` low mid-message before the grant is revoked (1..65535).

Ports:
- `sysclk`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, NREQ: per-requester byte valid.
- `req_data`, in, 8*NREQ: per-requester byte. Requester i uses bits [8i+7:8i].
- `req_last`, in, NREQ: per-requester end-of-message flag, qualified by `req_valid`.
- `req_ready`, out, NREQ: per-requester byte accepted.
- `tx_valid`, out, 1: byte valid to the transmitter.
- `tx_data`, out, 8: byte to the transmitter.
- `tx_ready`, in, 1: transmitter can take a byte.
- `grant`, out, NREQ: one-hot current owner. All zero when no owner.
- `cur_id`, out, clog2(NREQ): index of the current owner. Holds its last value when no owner.
- `busy`, out, 1: high while a grant is held.
- `timeout_evt`, out, 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: owner selected.
- IDLE:
  - If any `req_valid` is high, pick the first requester with `req_valid` high, searching upward from `rr_ptr` with wrap.
  - Register `grant`/`cur_id` and go to GRANT.
  - Clear `burst_cnt` and `hold_cnt`.
  - If no request, stay in IDLE.
- GRANT, datapath (combinational):
  - `tx_valid = req_valid[cur_id]`
  - `tx_data = req_data[cur_id]`
  - `req_ready[cur_id] = tx_ready`
  - All other `req_ready` bits are 0.
- A beat is accepted when `tx_valid & tx_ready`. On each beat, `burst_cnt` increments (8-bit, saturating).
- Release conditions from GRANT, checked in priority order (go to IDLE, `rr_ptr <= (cur_id+1) mod NREQ`):
  1. Beat accepted with `req_last[cur_id]` high.
  2. Beat accepted with `burst_cnt == MAX_BURST-1`. This is a forced rotation: the owner re-arbitrates and continues its message later.
  3. `hold_cnt == HOLD_TIMEOUT-1` while `req_valid[cur_id]` is low. Pulse `timeout_evt`.
- `hold_cnt` (16-bit):
  - Increments each GRANT cycle in which `req_valid[cur_id]` is low.
  - Clears whenever `req_valid[cur_id]` is high.
- Requests from non-owners are ignored in GRANT. Requesters must hold `req_valid`/`req_data`/`req_last` stable until `req_ready`.
- `tx_ready` low while `req_valid` is high: this is a stall, not idle. `hold_cnt` does not advance.
- `rr_ptr` resets to 0 and is updated only on release.
- Reset mid-message: the grant drops at once and the partial message is abandoned. The transmitter's own reset handles any byte already in flight.

## Timing
- Reset values:
  - `grant=0`, `cur_id=0`, `busy=0`, `tx_valid=0`, `tx_data=0`, `req_ready=0`, `timeout_evt=0`.
  - state=IDLE, `rr_ptr=0`.
  - These hold while `reset` is high.
- Request to grant: `req_valid` high in cycle t (IDLE) gives `grant`/`busy` high from cycle t+1. The first beat can be accepted in t+1.
- Release: a release beat in cycle t gives state IDLE and `grant=0` in t+1. The next grant comes in t+2. The minimum inter-message gap is one idle cycle.
- Throughput: within a grant, one byte per cycle when `tx_ready` is high.
- Timeout: with `req_valid[cur_id]` low from the first GRANT cycle g, release happens at the end of cycle g+HOLD_TIMEOUT-1. `timeout_evt` is high in that cycle.
- Simultaneous `last` and burst limit on the same beat: a single release, treated as `last`.

## Structure
- Shared package `uart_pkg`:
  - `uart_byte_t` (8-bit).
  - Scheduler state encoding (IDLE, GRANT).
  - Width helper for `cur_id`.
- Sub-module `rr_arbiter`:
  - Combinational.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: one-hot `gnt`, `gnt_id`, `any`.
  - Instantiated once. Used only in IDLE.

## Test plan
- Single requester 2 sends a 3-byte message 0x41,0x42,0x43 with `last` on 0x43 and `tx_ready` held high -> `grant=0100` at t+1. Three consecutive beats on `tx_data`. IDLE at t+4. `rr_ptr=3`.
- All four requesters valid from reset, each with 2-byte messages -> grant order 0,1,2,3. One idle cycle between messages. No interleaved bytes.
- Requester 1 sends a 20-byte message with `MAX_BURST=16` and requester 3 waiting -> release after 16 bytes. Requester 3 is served next. Requester 1 resumes afterwards with byte 17.
- Owner drops `req_valid` for `HOLD_TIMEOUT` cycles (set to 8) -> `timeout_evt` pulses in the 8th low cycle. `grant=0` on the next cycle.
- `tx_ready` toggles 1,0,0,1 during a message -> bytes accepted only on ready cycles. Data stable while stalled. No timeout counting.
- `reset` asserted mid-message, asynchronously between edges -> `grant`, `tx_valid` and `req_ready` go to 0 immediately. After release of `reset`, arbitration restarts at requester 0.
